// File: rtl/pri_icache_ctrl_responder_if.sv
// Control/handshake bundle between the cache master and the icache control responder.
// Signal names keep their original _i/_o suffixes as seen from the responder.
interface pri_icache_ctrl_responder_if #(
    parameter int unsigned NB_SETS = 32
);
    localparam int unsigned SET_W = $clog2(NB_SETS);

    logic                 bypass_req_i;
    logic                 bypass_ack_o;
    logic                 flush_req_i;
    logic                 flush_ack_o;
    logic                 sel_flush_req_i;
    logic [31:0]          sel_flush_addr_i;
    logic                 sel_flush_ack_o;
    logic                 ctrl_clear_regs_i;
    logic                 ctrl_enable_regs_i;
    logic [31:0]          ctrl_hit_count_o;
    logic [31:0]          ctrl_trans_count_o;
    logic [31:0]          ctrl_miss_count_o;
    logic [31:0]          ctrl_cong_count_o;
    logic                 evt_hit_i;
    logic                 evt_trans_i;
    logic                 evt_miss_i;
    logic                 evt_cong_i;
    logic                 refill_pending_i;
    logic                 ctrl_busy_o;
    logic                 bypass_en_o;
    logic                 tag_clr_o;
    logic [SET_W-1:0]     tag_clr_idx_o;

    modport master (
        output bypass_req_i, flush_req_i, sel_flush_req_i, sel_flush_addr_i,
               ctrl_clear_regs_i, ctrl_enable_regs_i,
               evt_hit_i, evt_trans_i, evt_miss_i, evt_cong_i, refill_pending_i,
        input  bypass_ack_o, flush_ack_o, sel_flush_ack_o,
               ctrl_hit_count_o, ctrl_trans_count_o, ctrl_miss_count_o, ctrl_cong_count_o,
               ctrl_busy_o, bypass_en_o, tag_clr_o, tag_clr_idx_o
    );

    modport slave (
        input  bypass_req_i, flush_req_i, sel_flush_req_i, sel_flush_addr_i,
               ctrl_clear_regs_i, ctrl_enable_regs_i,
               evt_hit_i, evt_trans_i, evt_miss_i, evt_cong_i, refill_pending_i,
        output bypass_ack_o, flush_ack_o, sel_flush_ack_o,
               ctrl_hit_count_o, ctrl_trans_count_o, ctrl_miss_count_o, ctrl_cong_count_o,
               ctrl_busy_o, bypass_en_o, tag_clr_o, tag_clr_idx_o
    );
endinterface

// File: rtl/pri_icache_ctrl_responder.sv
// Icache control responder: drains refills, then performs full/selective tag flushes
// and bypass-mode switches, and keeps four saturating statistics counters.
module pri_icache_ctrl_responder #(
    parameter int unsigned NB_SETS    = 32,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    pri_icache_ctrl_responder_if.slave     bus
);
    localparam int unsigned      SET_W    = $clog2(NB_SETS);
    localparam int unsigned      OFF_W    = $clog2(LINE_BYTES);
    localparam logic [SET_W-1:0] LAST_IDX = SET_W'(NB_SETS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH_ALL,
        ST_SEL_FLUSH,
        ST_ACK
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SET_W-1:0] r_clr_idx;
    logic [SET_W-1:0] r_sel_idx;
    logic             r_bypass_en;
    logic             r_op_full;
    logic             r_sel_seen;
    logic             r_post_ack;
    logic [31:0]      r_hit_cnt;
    logic [31:0]      r_trans_cnt;
    logic [31:0]      r_miss_cnt;
    logic [31:0]      r_cong_cnt;

    logic             w_bypass_diff;
    logic             w_flush_req;
    logic             w_sel_req;
    logic             w_bypass_load;
    logic             w_busy;
    logic             w_tag_clr;
    logic [SET_W-1:0] w_tag_clr_idx;
    logic             w_flush_ack;
    logic             w_sel_ack;
    logic             w_unused_addr;

    assign w_bypass_diff = bus.bypass_req_i != r_bypass_en;
    // Flush requests are masked for one cycle after ACK so the master can drop them.
    assign w_flush_req   = bus.flush_req_i & ~r_post_ack;
    assign w_sel_req     = bus.sel_flush_req_i & ~r_post_ack;
    assign w_unused_addr = ^bus.sel_flush_addr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_clr_idx   <= '0;
            r_sel_idx   <= '0;
            r_bypass_en <= 1'b0;
            r_op_full   <= 1'b0;
            r_sel_seen  <= 1'b0;
            r_post_ack  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_post_ack <= (r_state == ST_ACK);
            if (w_bypass_load)
                r_bypass_en <= bus.bypass_req_i;
            if (r_state == ST_DRAIN && w_next != ST_DRAIN) begin
                r_op_full <= (w_next == ST_FLUSH_ALL);
                r_sel_idx <= bus.sel_flush_addr_i[OFF_W +: SET_W];
            end
            if (r_state == ST_FLUSH_ALL)
                r_clr_idx <= r_clr_idx + SET_W'(1);
            if (r_state == ST_IDLE)
                r_sel_seen <= 1'b0;
            else if (bus.sel_flush_req_i)
                r_sel_seen <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_bypass_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_flush_req || w_sel_req || w_bypass_diff)
                    w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!bus.refill_pending_i) begin
                    if (bus.flush_req_i)
                        w_next = ST_FLUSH_ALL;
                    else if (bus.sel_flush_req_i)
                        w_next = ST_SEL_FLUSH;
                    else begin
                        w_bypass_load = 1'b1;
                        w_next        = ST_IDLE;
                    end
                end
            end
            ST_FLUSH_ALL: begin
                if (r_clr_idx == LAST_IDX)
                    w_next = ST_ACK;
            end
            ST_SEL_FLUSH: w_next = ST_ACK;
            ST_ACK: begin
                w_bypass_load = 1'b1;
                w_next        = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy        = (r_state != ST_IDLE);
        w_tag_clr     = 1'b0;
        w_tag_clr_idx = r_clr_idx;
        w_flush_ack   = 1'b0;
        w_sel_ack     = 1'b0;
        case (r_state)
            ST_FLUSH_ALL: w_tag_clr = 1'b1;
            ST_SEL_FLUSH: begin
                w_tag_clr     = 1'b1;
                w_tag_clr_idx = r_sel_idx;
            end
            ST_ACK: begin
                // A full flush also satisfies any selective request seen meanwhile.
                if (r_op_full) begin
                    w_flush_ack = 1'b1;
                    w_sel_ack   = r_sel_seen | bus.sel_flush_req_i;
                end else begin
                    w_sel_ack   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ctrl_busy_o     = w_busy;
    assign bus.tag_clr_o       = w_tag_clr;
    assign bus.tag_clr_idx_o   = w_tag_clr_idx;
    assign bus.flush_ack_o     = w_flush_ack;
    assign bus.sel_flush_ack_o = w_sel_ack;
    assign bus.bypass_en_o     = r_bypass_en;
    assign bus.bypass_ack_o    = (r_bypass_en == bus.bypass_req_i) && !w_busy;

    function automatic logic [31:0] cnt_step(input logic [31:0] c, input logic ev);
        return (ev && c != '1) ? c + 32'd1 : c;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.ctrl_clear_regs_i) begin
            r_hit_cnt   <= '0;
            r_trans_cnt <= '0;
            r_miss_cnt  <= '0;
            r_cong_cnt  <= '0;
        end else if (bus.ctrl_enable_regs_i) begin
            r_hit_cnt   <= cnt_step(r_hit_cnt,   bus.evt_hit_i);
            r_trans_cnt <= cnt_step(r_trans_cnt, bus.evt_trans_i);
            r_miss_cnt  <= cnt_step(r_miss_cnt,  bus.evt_miss_i);
            r_cong_cnt  <= cnt_step(r_cong_cnt,  bus.evt_cong_i);
        end
    end

    assign bus.ctrl_hit_count_o   = r_hit_cnt;
    assign bus.ctrl_trans_count_o = r_trans_cnt;
    assign bus.ctrl_miss_count_o  = r_miss_cnt;
    assign bus.ctrl_cong_count_o  = r_cong_cnt;
endmodule

// File: tb/tb_pri_icache_ctrl_responder.sv
// Bench for pri_icache_ctrl_responder: vector table of flush/bypass operations with a
// tag-clear/ack scoreboard, plus hand sequences for bypass, reset abort and counters.
module tb_pri_icache_ctrl_responder;
    localparam int unsigned NB_SETS = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pri_icache_ctrl_responder_if #(.NB_SETS(NB_SETS)) bus_if ();

    pri_icache_ctrl_responder #(.NB_SETS(NB_SETS), .LINE_BYTES(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    typedef struct {
        bit          clr;
        logic [4:0]  idx;
        bit          fack;
        bit          sack;
    } ev_t;

    typedef struct {
        string       name;
        bit          full;
        bit          sel;
        logic [31:0] addr;
        int unsigned refill;
        bit          byp;
        bit          drop;
        logic [4:0]  sidx;
        bit          fack;
        bit          sack;
        int unsigned lat;
    } vec_t;

    ev_t         sb_q[$];
    bit          sb_on = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    bit          m_byp = 1'b0;
    logic [31:0] m_cnt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every tag clear or ack pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (sb_on && (bus_if.tag_clr_o || bus_if.flush_ack_o || bus_if.sel_flush_ack_o)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {29'd0, bus_if.tag_clr_o, bus_if.flush_ack_o, bus_if.sel_flush_ack_o}, 32'd0);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                chk("sb_clr",  {31'd0, bus_if.tag_clr_o},       {31'd0, e.clr});
                if (e.clr)
                    chk("sb_idx", {27'd0, bus_if.tag_clr_idx_o}, {27'd0, e.idx});
                chk("sb_fack", {31'd0, bus_if.flush_ack_o},     {31'd0, e.fack});
                chk("sb_sack", {31'd0, bus_if.sel_flush_ack_o}, {31'd0, e.sack});
            end
        end
    end

    function automatic logic [31:0] cnt_rd(input int unsigned i);
        case (i)
            0:       return bus_if.ctrl_hit_count_o;
            1:       return bus_if.ctrl_trans_count_o;
            2:       return bus_if.ctrl_miss_count_o;
            default: return bus_if.ctrl_cong_count_o;
        endcase
    endfunction

    task automatic drive_cnt(input bit clr, input bit en, input logic [3:0] ev);
        bus_if.ctrl_clear_regs_i  = clr;
        bus_if.ctrl_enable_regs_i = en;
        bus_if.evt_hit_i   = ev[0];
        bus_if.evt_trans_i = ev[1];
        bus_if.evt_miss_i  = ev[2];
        bus_if.evt_cong_i  = ev[3];
        for (int unsigned i = 0; i < 4; i++) begin
            if (clr)
                m_cnt[i] = '0;
            else if (en && ev[i] && m_cnt[i] != 32'hFFFF_FFFF)
                m_cnt[i] = m_cnt[i] + 32'd1;
        end
        @(negedge clk);
        for (int unsigned i = 0; i < 4; i++)
            chk($sformatf("cnt%0d", i), cnt_rd(i), m_cnt[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{"full",          1'b1, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 34};
        vecs[1] = '{"sel_1f4",       1'b0, 1'b1, 32'h0000_01F4, 0, 1'b0, 1'b0, 5'h1F, 1'b0, 1'b1, 3};
        vecs[2] = '{"both",          1'b1, 1'b1, 32'h0000_0040, 0, 1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 34};
        vecs[3] = '{"sel_refill",    1'b0, 1'b1, 32'h1234_5678, 4, 1'b0, 1'b1, 5'h07, 1'b0, 1'b1, 6};
        vecs[4] = '{"full_ref_byp",  1'b1, 1'b0, 32'h0000_0000, 5, 1'b1, 1'b1, 5'h00, 1'b1, 1'b0, 38};
        vecs[5] = '{"sel_byp",       1'b0, 1'b1, 32'h0000_0010, 0, 1'b1, 1'b0, 5'h01, 1'b0, 1'b1, 3};

        rst = 1'b1;
        bus_if.bypass_req_i       = 1'b0;
        bus_if.flush_req_i        = 1'b0;
        bus_if.sel_flush_req_i    = 1'b0;
        bus_if.sel_flush_addr_i   = '0;
        bus_if.ctrl_clear_regs_i  = 1'b0;
        bus_if.ctrl_enable_regs_i = 1'b0;
        bus_if.evt_hit_i          = 1'b0;
        bus_if.evt_trans_i        = 1'b0;
        bus_if.evt_miss_i         = 1'b0;
        bus_if.evt_cong_i         = 1'b0;
        bus_if.refill_pending_i   = 1'b0;
        for (int unsigned i = 0; i < 4; i++) m_cnt[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_busy",    {31'd0, bus_if.ctrl_busy_o},     32'd0);
        chk("rst_tag_clr", {31'd0, bus_if.tag_clr_o},       32'd0);
        chk("rst_idx",     {27'd0, bus_if.tag_clr_idx_o},   32'd0);
        chk("rst_fack",    {31'd0, bus_if.flush_ack_o},     32'd0);
        chk("rst_sack",    {31'd0, bus_if.sel_flush_ack_o}, 32'd0);
        chk("rst_byp_en",  {31'd0, bus_if.bypass_en_o},     32'd0);
        chk("rst_byp_ack", {31'd0, bus_if.bypass_ack_o},    32'd1);
        for (int unsigned i = 0; i < 4; i++)
            chk($sformatf("rst_cnt%0d", i), cnt_rd(i), 32'd0);

        sb_on = 1'b1;
        for (int unsigned v = 0; v < 6; v++) begin
            int unsigned lat;
            int unsigned hold;
            bit          got;
            bit          byp_old;

            if (vecs[v].full) begin
                for (int unsigned s = 0; s < NB_SETS; s++)
                    sb_q.push_back('{1'b1, 5'(s), 1'b0, 1'b0});
            end else if (vecs[v].sel) begin
                sb_q.push_back('{1'b1, vecs[v].sidx, 1'b0, 1'b0});
            end
            sb_q.push_back('{1'b0, 5'd0, vecs[v].fack, vecs[v].sack});

            byp_old = m_byp;
            if (vecs[v].byp) begin
                m_byp = ~m_byp;
                bus_if.bypass_req_i = m_byp;
            end
            bus_if.flush_req_i      = vecs[v].full;
            bus_if.sel_flush_req_i  = vecs[v].sel;
            bus_if.sel_flush_addr_i = vecs[v].addr;
            bus_if.refill_pending_i = (vecs[v].refill > 0);
            hold = (vecs[v].refill > 0) ? vecs[v].refill : 1;

            got = 1'b0;
            lat = 0;
            for (int unsigned k = 1; k <= 200 && !got; k++) begin
                @(negedge clk);
                lat = k;
                if (k <= vecs[v].refill) begin
                    chk({vecs[v].name, "_refill_busy"},  {31'd0, bus_if.ctrl_busy_o}, 32'd1);
                    chk({vecs[v].name, "_refill_noclr"}, {31'd0, bus_if.tag_clr_o},   32'd0);
                end
                if (k == vecs[v].refill)
                    bus_if.refill_pending_i = 1'b0;
                if (vecs[v].drop && k == hold + 1) begin
                    bus_if.flush_req_i     = 1'b0;
                    bus_if.sel_flush_req_i = 1'b0;
                end
                if (bus_if.flush_ack_o || bus_if.sel_flush_ack_o)
                    got = 1'b1;
            end
            chk({vecs[v].name, "_latency"}, lat, vecs[v].lat);
            if (vecs[v].byp)
                chk({vecs[v].name, "_byp_during_ack"}, {31'd0, bus_if.bypass_en_o}, {31'd0, byp_old});

            @(negedge clk);
            chk({vecs[v].name, "_idle_busy"}, {31'd0, bus_if.ctrl_busy_o},  32'd0);
            chk({vecs[v].name, "_byp_en"},    {31'd0, bus_if.bypass_en_o},  {31'd0, m_byp});
            chk({vecs[v].name, "_byp_ack"},   {31'd0, bus_if.bypass_ack_o}, 32'd1);
            bus_if.flush_req_i     = 1'b0;
            bus_if.sel_flush_req_i = 1'b0;
            @(negedge clk);
            chk({vecs[v].name, "_req_ignored"}, {31'd0, bus_if.ctrl_busy_o}, 32'd0);
            chk({vecs[v].name, "_sb_empty"}, sb_q.size(), 32'd0);
            sb_q.delete();
            @(negedge clk);
        end

        // Bypass switch held off by an outstanding refill.
        bus_if.refill_pending_i = 1'b1;
        bus_if.bypass_req_i     = 1'b1;
        for (int unsigned k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("byp_wait_en",  {31'd0, bus_if.bypass_en_o},  32'd0);
            chk("byp_wait_ack", {31'd0, bus_if.bypass_ack_o}, 32'd0);
            if (k == 10)
                bus_if.refill_pending_i = 1'b0;
        end
        @(negedge clk);
        chk("byp_done_en",   {31'd0, bus_if.bypass_en_o},  32'd1);
        chk("byp_done_ack",  {31'd0, bus_if.bypass_ack_o}, 32'd1);
        chk("byp_done_busy", {31'd0, bus_if.ctrl_busy_o},  32'd0);
        bus_if.bypass_req_i = 1'b0;
        @(negedge clk);
        chk("byp_off_busy", {31'd0, bus_if.ctrl_busy_o},  32'd1);
        chk("byp_off_ack",  {31'd0, bus_if.bypass_ack_o}, 32'd0);
        @(negedge clk);
        chk("byp_off_en",   {31'd0, bus_if.bypass_en_o},  32'd0);
        chk("byp_off_ack2", {31'd0, bus_if.bypass_ack_o}, 32'd1);
        m_byp = 1'b0;

        // Reset in the middle of a full flush aborts it without an ack.
        sb_on = 1'b0;
        @(negedge clk);
        bus_if.flush_req_i = 1'b1;
        begin
            bit found;
            bit seen;
            found = 1'b0;
            for (int unsigned k = 1; k <= 60; k++) begin
                @(negedge clk);
                if (bus_if.tag_clr_o && bus_if.tag_clr_idx_o == 5'd7) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("rst_mid_found", {31'd0, found}, 32'd1);
            rst = 1'b1;
            bus_if.flush_req_i = 1'b0;
            @(negedge clk);
            chk("rst_mid_clr",  {31'd0, bus_if.tag_clr_o},     32'd0);
            chk("rst_mid_busy", {31'd0, bus_if.ctrl_busy_o},   32'd0);
            chk("rst_mid_idx",  {27'd0, bus_if.tag_clr_idx_o}, 32'd0);
            rst = 1'b0;
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (bus_if.flush_ack_o || bus_if.tag_clr_o)
                    seen = 1'b1;
            end
            chk("rst_mid_noack", {31'd0, seen}, 32'd0);
        end

        // Counters: random traffic, saturation from a preload, clear priority.
        for (int unsigned i = 0; i < 4; i++) m_cnt[i] = '0;
        for (int unsigned i = 0; i < 30; i++)
            drive_cnt(i == 15, $urandom_range(0, 3) != 0, 4'($urandom));

        bus_if.ctrl_enable_regs_i = 1'b0;
        bus_if.ctrl_clear_regs_i  = 1'b0;
        force dut.r_hit_cnt   = 32'hFFFF_FFFE;
        force dut.r_trans_cnt = 32'hFFFF_FFFE;
        force dut.r_miss_cnt  = 32'hFFFF_FFFE;
        force dut.r_cong_cnt  = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.r_hit_cnt;
        release dut.r_trans_cnt;
        release dut.r_miss_cnt;
        release dut.r_cong_cnt;
        for (int unsigned i = 0; i < 4; i++) m_cnt[i] = 32'hFFFF_FFFE;
        @(negedge clk);
        for (int unsigned i = 0; i < 4; i++)
            chk($sformatf("preload%0d", i), cnt_rd(i), m_cnt[i]);
        repeat (3) drive_cnt(1'b0, 1'b1, 4'hF);
        drive_cnt(1'b1, 1'b1, 4'hF);
        drive_cnt(1'b0, 1'b0, 4'hF);
        drive_cnt(1'b0, 1'b1, 4'b0101);
        drive_cnt(1'b0, 1'b1, 4'b1110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pri_icache_ctrl_responder.md
PRI_ICACHE_CTRL_RESPONDER -- requirements
Module: pri_icache_ctrl_responder

Interface
REQ-001 Parameter NB_SETS, default 32, number of cache sets; power of two, at least 2.
REQ-002 Parameter LINE_BYTES, default 16, cache line size in bytes; power of two. Derived widths: SET_W = log2(NB_SETS), OFF_W = log2(LINE_BYTES).
REQ-003 Ports: one clock and one reset; reset is synchronous and active-high.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- bypass_req_i  in  1  level; 1 requests cache bypass.
- bypass_ack_o  out  1  level; high when bypass_en_o equals bypass_req_i.
- flush_req_i  in  1  full-flush request, held until acked.
- flush_ack_o  out  1  one-cycle ack pulse.
- sel_flush_req_i  in  1  selective-flush request, held until acked.
- sel_flush_addr_i  in  32  address to flush; qualified by sel_flush_req_i.
- sel_flush_ack_o  out  1  one-cycle ack pulse.
- ctrl_clear_regs_i  in  1  zeroes the statistics counters.
- ctrl_enable_regs_i  in  1  enables statistics counting.
- ctrl_hit_count_o, ctrl_trans_count_o, ctrl_miss_count_o, ctrl_cong_count_o  out  32 each  statistics counters.
- evt_hit_i, evt_trans_i, evt_miss_i, evt_cong_i  in  1 each  per-cycle event strobes from the cache.
- refill_pending_i  in  1  cache has an outstanding refill.
- ctrl_busy_o  out  1  stalls new cache lookups.
- bypass_en_o  out  1  cache bypass mode.
- tag_clr_o  out  1  invalidates one tag set.
- tag_clr_idx_o  out  SET_W  index of the set to invalidate.

Function
REQ-004 The FSM SHALL have five states: IDLE, DRAIN, FLUSH_ALL, SEL_FLUSH and ACK. ctrl_busy_o is 1 in every state except IDLE.
REQ-005 In IDLE, if flush_req_i or sel_flush_req_i is high, or bypass_req_i differs from bypass_en_o, the FSM SHALL go to DRAIN.
REQ-006 In DRAIN, the FSM SHALL stay until refill_pending_i = 0, then pick the next state in this priority order:
- full flush -> FLUSH_ALL;
- selective flush -> SEL_FLUSH;
- bypass toggle only -> update bypass_en_o to bypass_req_i, then return to IDLE.
REQ-007 FLUSH_ALL SHALL hold tag_clr_o = 1 for exactly NB_SETS consecutive cycles, with tag_clr_idx_o counting 0, 1, ..., NB_SETS-1, then go to ACK.
REQ-008 SEL_FLUSH SHALL hold tag_clr_o = 1 for exactly one cycle with tag_clr_idx_o = sel_flush_addr_i[OFF_W +: SET_W], with the address captured on DRAIN exit, then go to ACK.
REQ-009 ACK SHALL last one cycle, then return to IDLE.
- After FLUSH_ALL: pulse flush_ack_o. If sel_flush_req_i is also high, pulse sel_flush_ack_o in the same cycle, since a full flush covers it.
- After SEL_FLUSH: pulse sel_flush_ack_o only.
REQ-010 Any pending bypass toggle SHALL be applied in ACK, since the pipe is already drained.
REQ-011 In the cycle directly after ACK, the FSM SHALL ignore flush_req_i and sel_flush_req_i, so the master has time to deassert them.
REQ-012 bypass_ack_o SHALL be combinational: (bypass_en_o == bypass_req_i) && !ctrl_busy_o.
REQ-013 A request deasserted before it is acked SHALL still complete the operation already begun, with the ack still pulsed.
REQ-014 Counters SHALL update as follows:
- each counter increments by 1 in a cycle where its event strobe is 1 and ctrl_enable_regs_i = 1;
- each counter saturates at 32'hFFFF_FFFF;
- ctrl_clear_regs_i = 1 zeroes all four counters and takes priority over increment in the same cycle.
REQ-015 Counter updates SHALL be independent of the FSM state.

Reset
REQ-016 While rst_i = 1 at a clock edge, the block SHALL set:
- state = IDLE;
- bypass_en_o, tag_clr_o, flush_ack_o, sel_flush_ack_o and ctrl_busy_o = 0;
- tag_clr_idx_o and all counters = 0.
REQ-017 A reset during DRAIN, FLUSH_ALL or SEL_FLUSH SHALL abort the operation with no ack; the master must re-request.

Verification
REQ-018 NB_SETS = 32, refill_pending_i = 0, flush_req_i rises at cycle 0 -> DRAIN at cycle 1; tag_clr_o high in cycles 2-33 with idx 0..31; flush_ack_o pulses at cycle 34.
REQ-019 sel_flush_addr_i = 32'h0000_01F4, LINE_BYTES = 16 -> exactly one tag_clr_o cycle with idx 5'h1F, then a single sel_flush_ack_o pulse.
REQ-020 flush_req_i and sel_flush_req_i asserted together -> 32 clear cycles, then flush_ack_o and sel_flush_ack_o pulse in the same cycle.
REQ-021 refill_pending_i held high for 10 cycles while bypass_req_i rises -> bypass_en_o stays 0 and bypass_ack_o stays 0 until the refill clears; then bypass_en_o = 1 and bypass_ack_o = 1.
REQ-022 rst_i asserted at clear index 7 of a full flush -> tag_clr_o = 0 and state IDLE next cycle; no flush_ack_o pulse.
REQ-023 Counters:
- counter preloaded to 32'hFFFF_FFFE, with enable and event high for 3 cycles -> reads 32'hFFFF_FFFF;
- clear and event high in the same cycle -> reads 0.
